// File: rtl/nes_mem_arbiter_if.sv
// rtl/nes_mem_arbiter_if.sv - host access port bundle for the NES memory arbiter
interface nes_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              host_req;
    logic              host_write;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    // Host side: issues requests, receives the acknowledge and read data
    modport master (
        output host_req, host_write, host_addr, host_wdata,
        input  host_ack, host_rdata
    );

    // Arbiter side
    modport slave (
        input  host_req, host_write, host_addr, host_wdata,
        output host_ack, host_rdata
    );
endinterface

// File: rtl/nes_mem_arbiter.sv
// rtl/nes_mem_arbiter.sv - shares program memory between the host port and the CPU
module nes_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    nes_mem_arbiter_if.slave    host,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_write,
    input  logic [DATA_W-1:0]   cpu_dout,
    output logic [DATA_W-1:0]   cpu_din,
    output logic                cpu_ready,
    output logic                cpu_reset,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_in,
    input  logic [DATA_W-1:0]   mem_out,
    output logic [ADDR_W-1:0]   program_end,
    output logic [1:0]          state
);

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOST = 2'd2;
    localparam logic [1:0] ST_HACK = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              from_run_q;
    logic              lat_write_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [ADDR_W-1:0] prog_end_q;
    logic              accept;
    logic [ADDR_W:0]   end_cand;

    // A host request is taken only from the idle-ish states; HACK ignores it
    assign accept   = ((state_q == ST_HALT) || (state_q == ST_RUN)) && host.host_req;
    // One extra bit so that 0xFFFF+1 is visible as an overflow and can saturate
    assign end_cand = {1'b0, host.host_addr} + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state selection; host_req outranks run in both HALT and RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (host.host_req)  state_d = ST_HOST;
                else if (run)       state_d = ST_RUN;
            end
            ST_RUN: begin
                if (host.host_req)  state_d = ST_HOST;
                else if (!run)      state_d = ST_HALT;
            end
            ST_HOST: state_d = ST_HACK;
            default: state_d = (from_run_q && run) ? ST_RUN : ST_HALT;
        endcase
    end

    // State, latched host request fields and the program high-water mark
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HALT;
            from_run_q  <= 1'b0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            prog_end_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                from_run_q  <= (state_q == ST_RUN);
                lat_write_q <= host.host_write;
                lat_addr_q  <= host.host_addr;
                lat_wdata_q <= host.host_wdata;
                if (host.host_write && (end_cand > {1'b0, prog_end_q})) begin
                    prog_end_q <= end_cand[ADDR_W] ? {ADDR_W{1'b1}} : end_cand[ADDR_W-1:0];
                end
            end
        end
    end

    // CPU control: the stall gate reacts to host_req in the same cycle
    always_comb begin
        cpu_ready = (state_q == ST_RUN) && !host.host_req;
        case (state_q)
            ST_HALT: cpu_reset = 1'b1;
            ST_RUN:  cpu_reset = 1'b0;
            default: cpu_reset = !from_run_q;
        endcase
    end

    // Memory port mux: host owns it in HOST, CPU only while it is ready
    always_comb begin
        mem_addr  = cpu_addr;
        mem_in    = cpu_dout;
        mem_write = 1'b0;
        if (state_q == ST_HOST) begin
            mem_addr  = lat_addr_q;
            mem_in    = lat_wdata_q;
            mem_write = lat_write_q;
        end else if (state_q == ST_HACK) begin
            mem_addr  = lat_addr_q;
            mem_in    = lat_wdata_q;
        end else if (cpu_ready) begin
            mem_write = cpu_write;
        end
    end

    // Acknowledge is exactly the HACK cycle, where memory data for the access is valid
    assign host.host_ack   = (state_q == ST_HACK);
    assign host.host_rdata = (state_q == ST_HACK) ? mem_out : '0;
    assign cpu_din         = mem_out;
    assign program_end     = prog_end_q;
    assign state           = state_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// tb/tb_nes_mem_arbiter.sv - scoreboard bench for nes_mem_arbiter
module tb_nes_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_ready;
    logic        cpu_reset;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic [7:0]  mem_in;
    logic [7:0]  mem_out;
    logic [15:0] program_end;
    logic [1:0]  state;

    nes_mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) hif ();

    nes_mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .run(run), .host(hif),
        .cpu_addr(cpu_addr), .cpu_write(cpu_write), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_ready(cpu_ready), .cpu_reset(cpu_reset),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_in(mem_in),
        .mem_out(mem_out), .program_end(program_end), .state(state)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_in;
        mem_out <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rdata;
        bit         chk_rd;
        int         ack_cyc;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int acks  = 0;
    bit prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (hif.host_ack) begin
            exp_t e;
            acks++;
            chk("ack_not_back_to_back", {31'd0, prev_ack}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_latency_cycle", e.ack_cyc, cyc);
                if (e.chk_rd) chk("host_rdata", {24'd0, hif.host_rdata}, {24'd0, e.rdata});
            end
        end
        prev_ack = hif.host_ack;
    end

    task automatic host_issue(input bit wr, input logic [15:0] a, input logic [7:0] d,
                              input logic [7:0] exp_rd, input bit chk_rd);
        exp_t e;
        hif.host_req   = 1'b1;
        hif.host_write = wr;
        hif.host_addr  = a;
        hif.host_wdata = d;
        e.rdata   = exp_rd;
        e.chk_rd  = chk_rd;
        e.ack_cyc = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic host_wait(input bit watch_no_write);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (watch_no_write) chk("read_mem_write", {31'd0, mem_write}, 32'd0);
            if (hif.host_ack) seen = 1'b1;
        end
        if (!seen) chk("ack_timeout", 32'd0, 32'd1);
        hif.host_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset = 1'b1; run = 1'b0;
        hif.host_req = 1'b0; hif.host_write = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
        cpu_addr = '0; cpu_write = 1'b0; cpu_dout = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_host_ack", hif.host_ack, 0);
        chk("rst_host_rdata", hif.host_rdata, 0);
        chk("rst_program_end", program_end, 0);
        reset = 1'b0;

        @(negedge clk); host_issue(1'b1, 16'h0000, 8'hA9, 8'h00, 1'b0); host_wait(1'b0);
        @(negedge clk); host_issue(1'b1, 16'h0001, 8'h05, 8'h00, 1'b0); host_wait(1'b0);
        chk("program_end_after_writes", program_end, 16'h0002);

        @(negedge clk); host_issue(1'b0, 16'h0001, 8'h00, 8'h05, 1'b1); host_wait(1'b1);
        chk("program_end_after_read", program_end, 16'h0002);

        @(negedge clk); run = 1'b1;
        @(negedge clk);
        chk("run_state", state, 1);
        chk("run_cpu_reset", cpu_reset, 0);
        chk("run_cpu_ready", cpu_ready, 1);
        cpu_addr = 16'h1234; #1;
        chk("run_mem_addr_a", mem_addr, 16'h1234);
        cpu_addr = 16'h0BEE; #1;
        chk("run_mem_addr_b", mem_addr, 16'h0BEE);

        @(negedge clk);
        cpu_addr = 16'h0010; cpu_dout = 8'hEE; cpu_write = 1'b1;
        host_issue(1'b0, 16'h0000, 8'h00, 8'hA9, 1'b1);
        #1;
        chk("stall_cpu_ready", cpu_ready, 0);
        chk("stall_mem_write", mem_write, 0);
        @(negedge clk);
        chk("stall_host_state", state, 2);
        chk("stall_host_cpu_reset", cpu_reset, 0);
        chk("stall_host_mem_write", mem_write, 0);
        host_wait(1'b0);
        cpu_write = 1'b0;
        @(negedge clk);
        chk("stall_back_run", state, 1);
        chk("stall_back_ready", cpu_ready, 1);
        chk("stall_cpu_write_blocked", mem[16'h0010], 8'h00);

        run = 1'b0;
        @(negedge clk);
        chk("halt_again", state, 0);
        run = 1'b1;
        host_issue(1'b1, 16'hFFFF, 8'h42, 8'h00, 1'b0);
        #1;
        chk("prio_cpu_ready", cpu_ready, 0);
        host_wait(1'b0);
        @(negedge clk);
        chk("prio_after_hack_halt", state, 0);
        @(negedge clk);
        chk("prio_then_run", state, 1);
        chk("program_end_saturated", program_end, 16'hFFFF);

        run = 1'b0;
        repeat (2) @(negedge clk);
        hif.host_req = 1'b1; hif.host_write = 1'b1; hif.host_addr = 16'h0003; hif.host_wdata = 8'h77;
        @(negedge clk);
        chk("abort_in_host", state, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; hif.host_req = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_program_end", program_end, 0);
        chk("abort_no_ack_now", hif.host_ack, 0);
        repeat (4) @(negedge clk);
        chk("abort_state_later", state, 0);

        chk("total_acks", acks, 5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
